// File: rtl/csa_resolve.sv
// ---------------------------------------------------------------------------
// csa_resolve
//
// Carry-save resolver. It accepts a redundant sum/carry vector pair and merges
// it into one two's-complement word. The merge is chunk-serial and LSB-first:
// CHUNK bits are added per cycle, with a registered carry between chunks, so
// the combinational carry chain is only CHUNK bits long.
//
// Ports
//   clk        rising-edge clock
//   r          synchronous, active-high reset
//   s_in       carry-save sum vector (WIDTH bits)
//   c_in       carry-save carry vector, weight-aligned to s_in (WIDTH bits)
//   in_valid   s_in/c_in valid
//   in_ready   block can accept an operand pair (high only in IDLE)
//   y          resolved result, (s_in + c_in) mod 2^WIDTH
//   y_cout     unsigned carry out of bit WIDTH-1
//   y_ovf      two's-complement overflow of s_in + c_in
//   out_valid  y/y_cout/y_ovf valid (high only in DONE)
//   out_ready  consumer accepts the result
//   busy       high in ADD or DONE
//
// Timing: accept at edge E, out_valid first high after edge E+N where
// N = WIDTH/CHUNK. The earliest next accept is at edge E+N+2.
// ---------------------------------------------------------------------------
module csa_resolve #(
   parameter int WIDTH = 10,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             r,
   input  logic [WIDTH-1:0] s_in,
   input  logic [WIDTH-1:0] c_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] y,
   output logic             y_cout,
   output logic             y_ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   localparam int N     = WIDTH / CHUNK;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   generate
      if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
         $error("csa_resolve: WIDTH must be an integer multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   // Operands and result are viewed as N chunks, so that chunk k is simply
   // element [k] and the counter can index it directly.
   logic [N-1:0][CHUNK-1:0] s_reg;
   logic [N-1:0][CHUNK-1:0] c_reg;
   logic [N-1:0][CHUNK-1:0] y_reg;
   logic                    carry;
   logic [CNT_W-1:0]        cnt;
   logic                    cout_reg;
   logic                    ovf_reg;

   logic [CHUNK:0]          chunk_sum;
   logic                    last_chunk;
   logic                    accept;

   // One chunk of the ripple add. The result is CHUNK+1 bits wide; its MSB
   // is the chunk carry-out.
   function automatic logic [CHUNK:0] chunk_add(
      input logic [CHUNK-1:0] a,
      input logic [CHUNK-1:0] b,
      input logic             cin
   );
      chunk_add = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
   endfunction

   // Signed overflow: both operands have the same sign and the result sign
   // differs from it.
   function automatic logic add_overflow(
      input logic sign_a,
      input logic sign_b,
      input logic sign_r
   );
      add_overflow = (sign_a == sign_b) && (sign_r != sign_a);
   endfunction

   always_comb begin
      chunk_sum  = chunk_add(s_reg[cnt], c_reg[cnt], carry);
      last_chunk = (cnt == CNT_W'(N - 1));
      accept     = in_ready && in_valid;
   end

   // State register
   always_ff @(posedge clk) begin
      if (r) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and handshake outputs
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = ADD;
            end
         end
         ADD: begin
            busy = 1'b1;
            if (last_chunk) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Operand capture and chunk-serial merge. The result and flags are only
   // written in ADD, so they stay stable through DONE and back into IDLE.
   always_ff @(posedge clk) begin
      if (r) begin
         s_reg    <= '0;
         c_reg    <= '0;
         y_reg    <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         cout_reg <= 1'b0;
         ovf_reg  <= 1'b0;
      end else if (accept) begin
         s_reg <= s_in;
         c_reg <= c_in;
         carry <= 1'b0;
         cnt   <= '0;
      end else if (state == ADD) begin
         y_reg[cnt] <= chunk_sum[CHUNK-1:0];
         carry      <= chunk_sum[CHUNK];
         cnt        <= cnt + 1'b1;
         if (last_chunk) begin
            cout_reg <= chunk_sum[CHUNK];
            ovf_reg  <= add_overflow(s_reg[N-1][CHUNK-1],
                                     c_reg[N-1][CHUNK-1],
                                     chunk_sum[CHUNK-1]);
         end
      end
   end

   assign y      = y_reg;
   assign y_cout = cout_reg;
   assign y_ovf  = ovf_reg;

endmodule

// File: tb/tb_csa_resolve.sv
// ---------------------------------------------------------------------------
// tb_csa_resolve
//
// Self-checking bench for csa_resolve (WIDTH=10, CHUNK=2). A transaction-level
// model predicts the handshake outputs and the result from plain integer
// arithmetic. One compare process checks the model against the DUT on every
// falling edge. Directed tasks also pin literal results and latencies.
// ---------------------------------------------------------------------------
module tb_csa_resolve;

   localparam int WIDTH = 10;
   localparam int CHUNK = 2;
   localparam int N     = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             r;
   logic [WIDTH-1:0] s_in;
   logic [WIDTH-1:0] c_in;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] y;
   logic             y_cout;
   logic             y_ovf;
   logic             out_valid;
   logic             out_ready;
   logic             busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   csa_resolve #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .r         (r),
      .s_in      (s_in),
      .c_in      (c_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .y         (y),
      .y_cout    (y_cout),
      .y_ovf     (y_ovf),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic: returns {ovf, cout, y[9:0]}.
   function automatic logic [11:0] ref_add(input logic [9:0] a, input logic [9:0] b);
      int         sa;
      int         sb;
      int         ss;
      logic [10:0] u;
      sa = $signed(a);
      sb = $signed(b);
      ss = sa + sb;
      u  = {1'b0, a} + {1'b0, b};
      return {(ss > 511) || (ss < -512), u};
   endfunction

   // Transaction model: the block is either free, counting down N merge
   // cycles, or holding a result until the consumer takes it.
   logic        m_init   = 1'b0;
   logic        m_busy   = 1'b0;
   logic        m_valid  = 1'b0;
   logic        m_yknown = 1'b0;
   int          m_cnt    = 0;
   logic [9:0]  m_y      = '0;
   logic        m_cout   = 1'b0;
   logic        m_ovf    = 1'b0;

   always @(posedge clk) begin
      if (r) begin
         m_init   = 1'b1;
         m_busy   = 1'b0;
         m_valid  = 1'b0;
         m_cnt    = 0;
         m_y      = '0;
         m_cout   = 1'b0;
         m_ovf    = 1'b0;
         m_yknown = 1'b1;
      end else if (m_init) begin
         if (!m_busy) begin
            if (in_valid) begin
               {m_ovf, m_cout, m_y} = ref_add(s_in, c_in);
               m_busy   = 1'b1;
               m_cnt    = N;
               m_yknown = 1'b0;
            end
         end else if (!m_valid) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_valid  = 1'b1;
               m_yknown = 1'b1;
            end
         end else if (out_ready) begin
            m_valid  = 1'b0;
            m_busy   = 1'b0;
            m_yknown = 1'b0;
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (m_init) begin
         chk("in_ready", in_ready, !m_busy);
         chk("busy", busy, m_busy);
         chk("out_valid", out_valid, m_valid);
         if (m_yknown) begin
            chk("y", y, m_y);
            chk("y_cout", y_cout, m_cout);
            chk("y_ovf", y_ovf, m_ovf);
         end
      end
   end

   // Call at a falling edge with the block idle. Holds out_ready low for
   // 'hold' cycles after out_valid rises, wiggling the inputs meanwhile.
   task automatic run_op(input logic [9:0] s, input logic [9:0] c,
                         input logic [9:0] ey, input logic ecout, input logic eovf,
                         input int hold);
      int k;
      s_in      = s;
      c_in      = c;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      chk("in_ready_drop", in_ready, 1'b0);
      k = 0;
      while (!out_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("latency", k, N);
      chk("lit_y", y, ey);
      chk("lit_cout", y_cout, ecout);
      chk("lit_ovf", y_ovf, eovf);
      chk("model_y", m_y, ey);
      chk("model_flags", {m_cout, m_ovf}, {ecout, eovf});
      for (int i = 0; i < hold; i++) begin
         in_valid = ~in_valid;
         s_in     = 10'($urandom);
         c_in     = 10'($urandom);
         @(negedge clk);
         chk("hold_y", y, ey);
         chk("hold_flags", {y_cout, y_ovf}, {ecout, eovf});
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_in_ready", in_ready, 1'b0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_valid", out_valid, 1'b0);
      chk("release_in_ready", in_ready, 1'b1);
      out_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int got;
      int last;
      int cyc;
      int k;

      // Reset with in_valid high: reset must win
      r         = 1'b1;
      in_valid  = 1'b1;
      s_in      = 10'h3FF;
      c_in      = 10'h001;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      r        = 1'b0;
      in_valid = 1'b0;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_y", y, 10'h000);
      chk("rst_flags", {y_cout, y_ovf}, 2'b00);
      @(negedge clk);

      // Directed vectors
      run_op(10'h155, 10'h0AB, 10'h200, 1'b0, 1'b1, 0);
      run_op(10'h3FF, 10'h001, 10'h000, 1'b1, 1'b0, 0);
      run_op(10'h200, 10'h200, 10'h000, 1'b1, 1'b1, 0);
      run_op(10'h0FF, 10'h100, 10'h1FF, 1'b0, 1'b0, 0);
      // Backpressure
      run_op(10'h123, 10'h2F0, 10'h013, 1'b1, 1'b0, 4);

      // Reset on the third ADD cycle
      s_in     = 10'h1AA;
      c_in     = 10'h155;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      r = 1'b1;
      @(negedge clk);
      r = 1'b0;
      chk("midrst_in_ready", in_ready, 1'b1);
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_y", y, 10'h000);
      chk("midrst_flags", {y_cout, y_ovf}, 2'b00);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("midrst_no_valid", out_valid, 1'b0);
      end
      run_op(10'h001, 10'h001, 10'h002, 1'b0, 1'b0, 0);

      // Back-to-back stream
      in_valid  = 1'b1;
      out_ready = 1'b1;
      got  = 0;
      last = -1;
      cyc  = 0;
      while (got < 8 && cyc < 200) begin
         if (in_ready) begin
            if (last >= 0) chk("accept_spacing", cyc - last, N + 2);
            last = cyc;
            s_in = 10'($urandom);
            c_in = 10'($urandom);
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      chk("stream_accepts", got, 8);
      k = 0;
      while (!in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("stream_drain", in_ready, 1'b1);
      out_ready = 1'b0;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/csa_resolve.md
Name: csa_resolve

Overview:
- Carry-save resolver: accepts a redundant sum/carry vector pair, as produced by the team's carry-save accumulator slices, and merges it into one binary word.
- Sits downstream of the carry-save accumulator in the adaptive-filter datapath. Feeds the error/output stage, which needs a conventional two's-complement value.
- Merge is chunk-serial, LSB-first: CHUNK bits per cycle with a registered carry. This keeps the carry chain short.
- Valid/ready handshake on both sides.

Parameters:
- WIDTH, 10: bit width of s_in, c_in and y.
- CHUNK, 2: bits merged per cycle. WIDTH must be an integer multiple of CHUNK; violation is an elaboration-time error.

Ports:
- clk  input  1  clock; all state updates on rising edge
- r  input  1  synchronous, active-high reset
- s_in  input  WIDTH  carry-save sum vector
- c_in  input  WIDTH  carry-save carry vector, already weight-aligned to s_in (bit i of c_in has weight 2^i)
- in_valid  input  1  s_in/c_in valid
- in_ready  output  1  block can accept an operand pair
- y  output  WIDTH  resolved result, (s_in + c_in) mod 2^WIDTH
- y_cout  output  1  unsigned carry out of bit WIDTH-1
- y_ovf  output  1  two's-complement overflow of s_in + c_in
- out_valid  output  1  y/y_cout/y_ovf valid
- out_ready  input  1  consumer accepts result
- busy  output  1  high in ADD or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset r is synchronous and active-high.
- Reset values: state=IDLE; in_ready=1; out_valid=0; busy=0; y=0; y_cout=0; y_ovf=0. Chunk counter, carry register and operand registers all 0.
- N = WIDTH/CHUNK.
- IDLE:
  - in_ready=1.
  - When in_valid=1, capture s_in and c_in into internal registers, clear the carry register and counter, and go to ADD.
  - When in_valid=0, stay in IDLE.
- ADD (in_ready=0, busy=1):
  - Each cycle, chunk k = counter, bits [k*CHUNK +: CHUNK]. Compute s_chunk + c_chunk + carry.
  - Write the CHUNK-bit result into y[k*CHUNK +: CHUNK] and store the chunk carry-out in the carry register. Increment the counter.
  - On the cycle processing chunk N-1:
    - y_cout = final carry out.
    - y_ovf = (s_reg[WIDTH-1] == c_reg[WIDTH-1]) && (result bit WIDTH-1 != s_reg[WIDTH-1]).
    - Next state DONE.
  - Exactly N cycles in ADD.
- DONE (out_valid=1, in_ready=0, busy=1):
  - y, y_cout and y_ovf are held stable.
  - When out_ready=1, go to IDLE and drop out_valid on the next edge.
  - out_ready=0 holds indefinitely with outputs unchanged.
- Latency: accept handshake at edge E; out_valid first high after edge E+N; earliest next accept at edge E+N+2 (DONE→IDLE at E+N+1).
- y is visible while updating during ADD. Consumers sample y only with out_valid=1.
- Input changes while in_ready=0 are ignored; operands are fully registered at accept.
- Any state, r=1 (including mid-ADD and DONE with out_valid high): next edge returns to the reset values and discards the in-flight operation. No output handshake completes for it.
- r and in_valid both 1 in IDLE: reset wins; nothing captured.
- Arithmetic is purely modulo 2^WIDTH. No saturation; y_ovf only flags.

Test Plan:
- WIDTH=10, CHUNK=2; reset, then s_in=10'h155, c_in=10'h0AB, in_valid pulse:
  - in_ready drops next cycle.
  - out_valid rises exactly 5 cycles after the accept edge, with y=10'h200, y_cout=0, y_ovf=1.
- s_in=10'h3FF, c_in=10'h001, out_ready=1: y=10'h000, y_cout=1, y_ovf=0. Carry ripples across all 5 chunk boundaries.
- s_in=10'h200, c_in=10'h200: y=10'h000, y_cout=1, y_ovf=1. Then s_in=10'h0FF, c_in=10'h100: y=10'h1FF, y_cout=0, y_ovf=0.
- Backpressure: hold out_ready=0 for 4 cycles after out_valid rises:
  - y, flags and out_valid stay stable; in_ready stays 0.
  - Toggling in_valid/s_in/c_in meanwhile has no effect.
  - Raising out_ready returns to IDLE next edge.
- Reset mid-operation: assert r=1 for 1 cycle on the 3rd ADD cycle:
  - All outputs at reset values next edge, in_ready=1, no out_valid pulse.
  - A following pair 10'h001 + 10'h001 yields y=10'h002 with normal latency.
- Back-to-back stream of 8 random pairs with in_valid held high and out_ready=1:
  - Every result matches (s+c) mod 1024 and the carry/overflow reference model.
  - Accepts are spaced exactly N+2=7 cycles apart.
